// File: rtl/core_lsu_stall_ctrl_if.sv
// Data-memory port of the load/store unit: request fields out, ack/read data back.
interface core_lsu_stall_ctrl_if;
  logic        dmem_req_out;
  logic        dmem_we_out;
  logic [3:0]  dmem_be_out;
  logic [31:0] dmem_addr_out;
  logic [31:0] dmem_wdata_out;
  logic        dmem_ack_in;
  logic [31:0] dmem_rdata_in;

  modport master (
    output dmem_req_out, dmem_we_out, dmem_be_out, dmem_addr_out, dmem_wdata_out,
    input  dmem_ack_in, dmem_rdata_in
  );

  modport slave (
    input  dmem_req_out, dmem_we_out, dmem_be_out, dmem_addr_out, dmem_wdata_out,
    output dmem_ack_in, dmem_rdata_in
  );
endinterface

// File: rtl/core_lsu_stall_ctrl.sv
// Mem-stage load/store unit: turns a pipeline load/store into a req/ack bus
// transaction, freezes the pipeline until it completes, aligns/extends load
// data, builds store byte enables and flags misaligned or timed-out accesses.
module core_lsu_stall_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_req_valid_in,
  input  logic        lsu_we_in,
  input  logic [1:0]  lsu_size_in,
  input  logic        lsu_sign_in,
  input  logic [31:0] lsu_addr_in,
  input  logic [31:0] lsu_wdata_in,
  input  logic        lsu_kill_in,
  output logic        lsu_stall_out,
  output logic [31:0] lsu_rdata_out,
  output logic        lsu_rdata_vld_out,
  output logic        lsu_misalign_out,
  output logic        lsu_err_out,
  core_lsu_stall_ctrl_if.master dmem
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_req;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_sign;
  logic [1:0]  r_off;
  logic        r_kill;
  logic [TO_W-1:0] r_cnt;
  logic [31:0] r_rdata;
  logic        r_rdata_vld;
  logic        r_err;

  logic        w_misalign;
  logic        w_present;
  logic        w_accept;
  logic        w_ack;
  logic        w_timeout;
  logic        w_kill_now;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shift;
  logic [31:0] w_load;

  // Access legality, request acceptance and REQ-phase completion conditions.
  always_comb begin
    w_misalign = (lsu_size_in == 2'b11) ||
                 ((lsu_size_in == 2'b01) && lsu_addr_in[0]) ||
                 ((lsu_size_in == 2'b10) && (lsu_addr_in[1:0] != 2'b00));
    w_present  = (r_state == S_IDLE) && lsu_req_valid_in && !lsu_kill_in;
    w_accept   = w_present && !w_misalign;
    w_ack      = (r_state == S_REQ) && dmem.dmem_ack_in;
    w_timeout  = (r_state == S_REQ) && !dmem.dmem_ack_in &&
                 (r_cnt == TO_W'(TIMEOUT - 1));
    w_kill_now = r_kill || lsu_kill_in;
  end

  // Store lane replication and byte enables; loads fetch the whole word.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = '0;
    if (lsu_we_in) begin
      case (lsu_size_in)
        2'b00: begin
          w_be    = 4'b0001 << lsu_addr_in[1:0];
          w_wdata = {4{lsu_wdata_in[7:0]}};
        end
        2'b01: begin
          w_be    = 4'b0011 << lsu_addr_in[1:0];
          w_wdata = {2{lsu_wdata_in[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = lsu_wdata_in;
        end
      endcase
    end
  end

  // Load alignment: shift the selected lane down, then sign/zero-extend.
  always_comb begin
    w_shift = dmem.dmem_rdata_in >> {r_off, 3'b000};
    case (r_size)
      2'b00:   w_load = {{24{r_sign & w_shift[7]}},  w_shift[7:0]};
      2'b01:   w_load = {{16{r_sign & w_shift[15]}}, w_shift[15:0]};
      default: w_load = w_shift;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state and the combinational pipeline-facing outputs.
  always_comb begin
    w_next           = r_state;
    lsu_stall_out    = 1'b0;
    lsu_misalign_out = 1'b0;
    case (r_state)
      S_IDLE: begin
        lsu_stall_out    = rst_n && w_accept;
        lsu_misalign_out = rst_n && w_present && w_misalign;
        if (w_accept) w_next = S_REQ;
      end
      S_REQ: begin
        lsu_stall_out = rst_n;
        if (w_ack || w_timeout) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture, timeout counting, and completion results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_be        <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_size      <= '0;
      r_sign      <= 1'b0;
      r_off       <= '0;
      r_kill      <= 1'b0;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_rdata_vld <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_rdata_vld <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_req   <= 1'b1;
            r_we    <= lsu_we_in;
            r_be    <= w_be;
            r_addr  <= {lsu_addr_in[31:2], 2'b00};
            r_wdata <= w_wdata;
            r_size  <= lsu_size_in;
            r_sign  <= lsu_sign_in;
            r_off   <= lsu_addr_in[1:0];
            r_kill  <= 1'b0;
            r_cnt   <= '0;
          end
        end
        S_REQ: begin
          // A kill arriving in the ack/timeout cycle itself still counts.
          if (w_ack) begin
            r_req       <= 1'b0;
            r_rdata     <= r_we ? '0 : w_load;
            r_rdata_vld <= !r_we && !w_kill_now;
          end else if (w_timeout) begin
            r_req   <= 1'b0;
            r_rdata <= '0;
            r_err   <= !w_kill_now;
          end else begin
            r_cnt  <= r_cnt + TO_W'(1);
            r_kill <= w_kill_now;
          end
        end
        default: ;
      endcase
    end
  end

  assign dmem.dmem_req_out   = r_req;
  assign dmem.dmem_we_out    = r_we;
  assign dmem.dmem_be_out    = r_be;
  assign dmem.dmem_addr_out  = r_addr;
  assign dmem.dmem_wdata_out = r_wdata;
  assign lsu_rdata_out       = r_rdata;
  assign lsu_rdata_vld_out   = r_rdata_vld;
  assign lsu_err_out         = r_err;

endmodule
